// File: rtl/ps2_pkg.sv
// -----------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 device-to-host receive path and the
// downstream keyboard event filter.
//   ps2_rx_state_t   receiver FSM state encoding (IDLE, DATA, PARITY, STOP)
//   PS2_BREAK        scan-code prefix marking a key release (8'hF0)
//   PS2_EXTEND       scan-code prefix marking an extended key (8'hE0)
//   PS2_FILTER_LEN_DEFAULT / PS2_TIMEOUT_DEFAULT  default block parameters
//   odd_parity_ok()  odd-parity check over a data byte plus its parity bit
// -----------------------------------------------------------------------------
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_rx_state_t;

    localparam logic [7:0] PS2_BREAK  = 8'hF0;
    localparam logic [7:0] PS2_EXTEND = 8'hE0;

    localparam int PS2_FILTER_LEN_DEFAULT = 8;
    localparam int PS2_TIMEOUT_DEFAULT    = 50000;

    // A PS/2 frame is good when the eight data bits and the parity bit
    // together hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// -----------------------------------------------------------------------------
// ps2_sync_filter
// Brings the raw, asynchronous PS/2 lines into the clk_50mhz domain and
// deglitches the clock line.
//   clk_50mhz  in   system clock
//   reset_n    in   asynchronous active-low reset
//   ps2c       in   raw PS/2 clock
//   ps2d       in   raw PS/2 data
//   ps2d_sync  out  ps2d after a 2-flop synchronizer
//   fall       out  one-cycle pulse when the filtered ps2c goes 1 -> 0
// The filtered clock only changes after FILTER_LEN consecutive synchronized
// samples that disagree with it; any agreeing sample restarts the run.
// Raw edge to fall: 2 sync + FILTER_LEN filter + 1 edge-detect cycles.
// -----------------------------------------------------------------------------
module ps2_sync_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = PS2_FILTER_LEN_DEFAULT
) (
    input  logic clk_50mhz,
    input  logic reset_n,
    input  logic ps2c,
    input  logic ps2d,
    output logic ps2d_sync,
    output logic fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    c_sync_r;
    logic [1:0]    d_sync_r;
    logic          filt_r;
    logic          filt_d_r;
    logic          fall_r;
    logic [CW-1:0] run_r;

    logic [CW-1:0] run_next_s;
    logic          filt_next_s;

    // Two-flop synchronizers; both idle high so release from reset is quiet.
    always_ff @(posedge clk_50mhz or negedge reset_n) begin
        if (!reset_n) begin
            c_sync_r <= 2'b11;
            d_sync_r <= 2'b11;
        end else begin
            c_sync_r <= {c_sync_r[0], ps2c};
            d_sync_r <= {d_sync_r[0], ps2d};
        end
    end

    // Run-length filter next state: flip once FILTER_LEN disagreeing samples in a row.
    always_comb begin
        run_next_s  = run_r;
        filt_next_s = filt_r;
        if (c_sync_r[1] == filt_r) begin
            run_next_s  = '0;
            filt_next_s = filt_r;
        end else if (run_r == CW'(FILTER_LEN - 1)) begin
            run_next_s  = '0;
            filt_next_s = ~filt_r;
        end else begin
            run_next_s  = run_r + {{(CW-1){1'b0}}, 1'b1};
            filt_next_s = filt_r;
        end
    end

    // Filtered level, its one-cycle delayed copy and the registered fall pulse.
    always_ff @(posedge clk_50mhz or negedge reset_n) begin
        if (!reset_n) begin
            run_r    <= '0;
            filt_r   <= 1'b1;
            filt_d_r <= 1'b1;
            fall_r   <= 1'b0;
        end else begin
            run_r    <= run_next_s;
            filt_r   <= filt_next_s;
            filt_d_r <= filt_r;
            fall_r   <= filt_d_r & ~filt_r;
        end
    end

    assign ps2d_sync = d_sync_r[1];
    assign fall      = fall_r;

endmodule

// File: rtl/ps2_rx_frame.sv
// -----------------------------------------------------------------------------
// ps2_rx_frame
// PS/2 device-to-host receiver. Deserializes 11-bit frames (start, 8 data bits
// LSB first, odd parity, stop) and presents each good byte on a held bus.
//   clk_50mhz   in   system clock, 50 MHz
//   reset_n     in   asynchronous active-low reset
//   ps2c        in   raw PS/2 clock (asynchronous, never driven by this block)
//   ps2d        in   raw PS/2 data  (asynchronous, never driven by this block)
//   key_code    out  last correctly received byte, held until the next good frame
//   code_valid  out  one-cycle strobe in the cycle key_code updates
//   frame_err   out  one-cycle strobe on bad stop bit, parity failure or timeout
//   busy        out  high while a frame is in progress
// Build option: define PS2_PARITY_CHECK_EN to reject frames whose parity is
// wrong; otherwise the parity bit is sampled but only the stop bit gates
// acceptance.
// -----------------------------------------------------------------------------
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = PS2_FILTER_LEN_DEFAULT,
    parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_DEFAULT
) (
    input  logic       clk_50mhz,
    input  logic       reset_n,
    input  logic       ps2c,
    input  logic       ps2d,
    output logic [7:0] key_code,
    output logic       code_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_DATA   = DATA;
    localparam logic [1:0] ST_PARITY = PARITY;
    localparam logic [1:0] ST_STOP   = STOP;

    logic          ps2d_s;
    logic          fall_s;

    logic [1:0]    state_r;
    logic [2:0]    bit_idx_r;
    // Bits shift in at [8] and move right: after the parity bit the data byte
    // sits in [7:0] and parity in [8].
    logic [8:0]    shift_r;
    logic [TW-1:0] tmo_cnt_r;
    logic [7:0]    key_code_r;
    logic          code_valid_r;
    logic          frame_err_r;
    logic          busy_r;

    logic [1:0]    state_next_s;
    logic [2:0]    bit_idx_next_s;
    logic [8:0]    shift_next_s;
    logic [TW-1:0] tmo_cnt_next_s;
    logic [7:0]    key_code_next_s;
    logic          code_valid_next_s;
    logic          frame_err_next_s;
    logic          timeout_s;
    logic          parity_pass_s;

    ps2_sync_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_sync_filter (
        .clk_50mhz (clk_50mhz),
        .reset_n   (reset_n),
        .ps2c      (ps2c),
        .ps2d      (ps2d),
        .ps2d_sync (ps2d_s),
        .fall      (fall_s)
    );

`ifdef PS2_PARITY_CHECK_EN
    assign parity_pass_s = odd_parity_ok(shift_r[7:0], shift_r[8]);
`else
    assign parity_pass_s = 1'b1;
`endif

    assign timeout_s = (state_r != ST_IDLE) && (tmo_cnt_r == TW'(TIMEOUT_CYCLES - 1));

    // Inactivity counter: held at zero in IDLE and restarted by every bit.
    always_comb begin
        tmo_cnt_next_s = tmo_cnt_r;
        if ((state_r == ST_IDLE) || fall_s || timeout_s) begin
            tmo_cnt_next_s = '0;
        end else begin
            tmo_cnt_next_s = tmo_cnt_r + {{(TW-1){1'b0}}, 1'b1};
        end
    end

    // Frame FSM next state; a timeout overrides a coincident fall.
    always_comb begin
        state_next_s      = state_r;
        bit_idx_next_s    = bit_idx_r;
        shift_next_s      = shift_r;
        key_code_next_s   = key_code_r;
        code_valid_next_s = 1'b0;
        frame_err_next_s  = 1'b0;
        if (timeout_s) begin
            state_next_s     = ST_IDLE;
            bit_idx_next_s   = 3'd0;
            shift_next_s     = 9'd0;
            frame_err_next_s = 1'b1;
        end else if (fall_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (!ps2d_s) begin
                        state_next_s   = ST_DATA;
                        bit_idx_next_s = 3'd0;
                        shift_next_s   = 9'd0;
                    end else begin
                        state_next_s   = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    shift_next_s = {ps2d_s, shift_r[8:1]};
                    if (bit_idx_r == 3'd7) begin
                        state_next_s   = ST_PARITY;
                        bit_idx_next_s = 3'd0;
                    end else begin
                        bit_idx_next_s = bit_idx_r + 3'd1;
                    end
                end
                ST_PARITY: begin
                    shift_next_s = {ps2d_s, shift_r[8:1]};
                    state_next_s = ST_STOP;
                end
                ST_STOP: begin
                    if (ps2d_s && parity_pass_s) begin
                        key_code_next_s   = shift_r[7:0];
                        code_valid_next_s = 1'b1;
                    end else begin
                        frame_err_next_s  = 1'b1;
                    end
                    state_next_s = ST_IDLE;
                end
                default: begin
                    state_next_s   = ST_IDLE;
                    bit_idx_next_s = 3'd0;
                    shift_next_s   = 9'd0;
                end
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_50mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            bit_idx_r    <= 3'd0;
            shift_r      <= 9'd0;
            tmo_cnt_r    <= '0;
            key_code_r   <= 8'h00;
            code_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            bit_idx_r    <= bit_idx_next_s;
            shift_r      <= shift_next_s;
            tmo_cnt_r    <= tmo_cnt_next_s;
            key_code_r   <= key_code_next_s;
            code_valid_r <= code_valid_next_s;
            frame_err_r  <= frame_err_next_s;
            busy_r       <= (state_next_s != ST_IDLE);
        end
    end

    assign key_code   = key_code_r;
    assign code_valid = code_valid_r;
    assign frame_err  = frame_err_r;
    assign busy       = busy_r;

endmodule

// File: doc/ps2_rx_frame.md
# ps2_rx_frame

PS/2 device-to-host receiver: synchronizes and deglitches the raw `ps2c`/`ps2d` lines, deserializes 11-bit frames and presents each received byte on a held `key_code` bus plus a one-cycle `code_valid` strobe. It sits directly upstream of the keyboard event filter. That filter consumes `key_code` as a level that changes once per received byte, and turns make/break sequences (`F0`, `E0` prefixes) into single-cycle key pulses.

## Interface
- `FILTER_LEN`, 8: consecutive identical samples required before a filtered `ps2c` level changes.
- `TIMEOUT_CYCLES`, 50000: clocks without a filtered falling edge before a partial frame is abandoned (1 ms at 50 MHz).
- `clk_50mhz  input  1  system clock, 50 MHz`
- `reset_n  input  1  asynchronous, active-low reset`
- `ps2c  input  1  raw PS/2 clock, asynchronous`
- `ps2d  input  1  raw PS/2 data, asynchronous`
- `key_code  output  8  last correctly received byte, held until the next good frame`
- `code_valid  output  1  one-cycle strobe, asserted in the same cycle `key_code` updates`
- `frame_err  output  1  one-cycle strobe on bad stop bit, parity failure or timeout`
- `busy  output  1  high while a frame is in progress (state != IDLE)`

## Operation
- Both lines pass through a 2-flop synchronizer.
- Filtered `ps2c`:
  - resets to 1;
  - a run counter of width clog2(`FILTER_LEN`+1) counts consecutive samples that differ from the current filtered level;
  - the filtered level flips when the count reaches `FILTER_LEN`;
  - a sample equal to the current level clears the count.
- `fall` is a one-cycle pulse in the cycle the filtered clock goes 1→0. All bit sampling happens on `fall`, using the synchronized `ps2d`.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on `fall`, if data = 0 (start bit), go to DATA with bit index 0. If data = 1, ignore the edge and stay in IDLE.
  - DATA: on each `fall`, shift the data bit in LSB-first. After bit index 7, go to PARITY.
  - PARITY: on `fall`, latch the parity bit and go to STOP.
  - STOP: on `fall`:
    - if stop = 1 and the parity check passes: load `key_code` and pulse `code_valid`;
    - otherwise: pulse `frame_err` and leave `key_code` unchanged;
    - in both cases, return to IDLE.
- Parity is odd: the eight data bits plus the parity bit must contain an odd number of ones.
- Timeout:
  - the counter clears on every `fall` and while in IDLE;
  - when it reaches `TIMEOUT_CYCLES - 1` outside IDLE, pulse `frame_err`, discard the partial shift register and go to IDLE.
- If the timeout and a `fall` occur in the same cycle, the timeout wins.
- The block never drives the PS/2 lines. Host-to-device transfers are out of scope.

## Timing
- Reset values: `key_code` = 8'h00, `code_valid` = 0, `frame_err` = 0, `busy` = 0, FSM = IDLE, filtered clock = 1, shift register = 0.
- Latency, raw `ps2c` falling edge to `fall`: 2 (sync) + `FILTER_LEN` + 1 cycles = 11 cycles at default parameters.
- `code_valid`/`frame_err` are asserted 1 cycle after the `fall` that samples the stop bit. They are registered outputs, high for exactly 1 cycle.
- `code_valid` and `frame_err` are never high in the same cycle.
- Back-to-back frames need no idle gap: a start bit immediately after a stop bit is accepted.
- Reset asserted mid-frame: all state clears immediately; the partial frame is lost, with no strobe.
- Glitches on `ps2c` shorter than `FILTER_LEN` cycles produce no `fall`.

## Configuration
- `PS2_PARITY_CHECK_EN` defined: parity is checked as above, and a mismatch yields `frame_err` with no `key_code` update.
- Not defined: the parity bit is sampled but ignored, and only the stop bit gates acceptance.

## Structure
- Package `ps2_pkg`:
  - state enum `ps2_rx_state_t` (IDLE, DATA, PARITY, STOP);
  - constants `PS2_BREAK` = 8'hF0 and `PS2_EXTEND` = 8'hE0, shared with the downstream filter;
  - localparam for the default `FILTER_LEN`.
- Sub-module `ps2_sync_filter`: 2-flop synchronizers for both lines, the `ps2c` run-length filter and the `fall` pulse generator. The FSM, counters and outputs live in `ps2_rx_frame`.

## Test plan
- Frame for 0x1C (bits 0,0,0,1,1,1,0,0,0, parity 0, stop 1), 12 kHz `ps2c`:
  - `key_code` = 8'h1C, `code_valid` high exactly 1 cycle, `frame_err` never high.
- Frames F0 then 1C back-to-back, with no gap:
  - two `code_valid` strobes, with `key_code` going F0 then 1C.
- Frame 0x1C with parity bit 1:
  - with `PS2_PARITY_CHECK_EN`: `frame_err` pulse, and `key_code` keeps its prior value;
  - without it: `key_code` = 8'h1C.
- Stop bit driven 0:
  - `frame_err` pulse, no `code_valid`, FSM returns to IDLE, and the next good frame 0x29 is received correctly.
- Stop `ps2c` after 4 data bits:
  - `frame_err` exactly `TIMEOUT_CYCLES` cycles after the last `fall`, `busy` falls.
  - 3-cycle `ps2c` glitches injected mid-bit cause no extra bit shifts.
- Assert `reset_n` = 0 during DATA of frame 0x5A:
  - outputs return to reset values with no strobes;
  - after release, a full 0x5A frame yields `key_code` = 8'h5A.
